// File: rtl/asg_frame_loader.sv
// asg_frame_loader: double-buffered stream-to-frame loader for the azimuth signal generator.
// A back buffer fills from the word stream; TRIG promotes a complete frame to the DATA register.
module asg_frame_loader #(
    parameter int SIZE = 3200,
    parameter int WORD = 32
) (
    input  logic            SYS_CLK,
    input  logic            RST,
    input  logic [WORD-1:0] S_TDATA,
    input  logic            S_TVALID,
    output logic            S_TREADY,
    input  logic            S_TLAST,
    input  logic            TRIG,
    input  logic            ERR_CLR,
    output logic [SIZE-1:0] DATA,
    output logic            EN,
    output logic            LOADED,
    output logic            FRAME_ERR,
    output logic            UNDERRUN
);
    localparam int NW = SIZE / WORD;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {FILL, FULL, DISCARD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] back_q, data_q;
    logic            en_q, ferr_q, und_q;
    logic            wr, load, ferr_set, und_set, beat, at_end;

    assign S_TREADY  = !RST && state_q != FULL;
    assign beat      = S_TVALID && S_TREADY;
    assign at_end    = cnt_q == CW'(NW - 1);
    assign DATA      = data_q;
    assign EN        = en_q;
    assign LOADED    = state_q == FULL;
    assign FRAME_ERR = ferr_q;
    assign UNDERRUN  = und_q;

    // A TRIG outside FULL is always an underrun, including one that lands on the completing beat.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr       = 1'b0;
        load     = 1'b0;
        ferr_set = 1'b0;
        und_set  = TRIG && state_q != FULL;
        case (state_q)
            FILL: if (beat) begin
                if (!at_end && !S_TLAST) begin
                    wr    = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end else if (at_end && S_TLAST) begin
                    wr      = 1'b1;
                    cnt_d   = '0;
                    state_d = FULL;
                end else begin
                    ferr_set = 1'b1;
                    cnt_d    = '0;
                    state_d  = at_end ? DISCARD : FILL;
                end
            end
            FULL: if (TRIG) begin
                load    = 1'b1;
                cnt_d   = '0;
                state_d = FILL;
            end
            DISCARD: if (beat && S_TLAST) begin
                cnt_d   = '0;
                state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            ferr_q  <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ferr_q  <= ferr_set | (ferr_q & !ERR_CLR);
            und_q   <= und_set | (und_q & !ERR_CLR);
            if (load) begin
                data_q <= back_q;
                en_q   <= 1'b1;
            end
        end
    end

    // Beats are never accepted during reset, so the back buffer needs no reset of its own.
    always_ff @(posedge SYS_CLK) begin
        if (wr) back_q[cnt_q*WORD +: WORD] <= S_TDATA;
    end
endmodule

// File: tb/tb_asg_frame_loader.sv
// tb_asg_frame_loader: randomized scoreboard bench; a frame-level model predicts the outputs after
// every edge, and a monitor pops and compares them one cycle later.
module tb_asg_frame_loader;
    localparam int SIZE = 3200;
    localparam int WORD = 32;
    localparam int NW   = SIZE / WORD;

    logic            SYS_CLK = 1'b0;
    logic            RST = 1'b1;
    logic [WORD-1:0] S_TDATA = '0;
    logic            S_TVALID = 1'b0;
    logic            S_TLAST = 1'b0;
    logic            TRIG = 1'b0;
    logic            ERR_CLR = 1'b0;
    logic            S_TREADY, EN, LOADED, FRAME_ERR, UNDERRUN;
    logic [SIZE-1:0] DATA;

    asg_frame_loader #(.SIZE(SIZE), .WORD(WORD)) dut (
        .SYS_CLK(SYS_CLK), .RST(RST), .S_TDATA(S_TDATA), .S_TVALID(S_TVALID),
        .S_TREADY(S_TREADY), .S_TLAST(S_TLAST), .TRIG(TRIG), .ERR_CLR(ERR_CLR),
        .DATA(DATA), .EN(EN), .LOADED(LOADED), .FRAME_ERR(FRAME_ERR), .UNDERRUN(UNDERRUN)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    typedef struct {
        logic [4:0]      flags;
        logic [SIZE-1:0] data;
    } exp_t;

    exp_t            sb[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              n_cyc = 0;

    // Reference model: the frame under construction is simply a queue of words.
    logic [WORD-1:0] m_part[$];
    logic [SIZE-1:0] m_back = '0;
    logic [SIZE-1:0] m_front = '0;
    bit              m_full = 0, m_disc = 0, m_en = 0, m_ferr = 0, m_und = 0;

    task automatic cyc(input bit r, input bit v, input logic [WORD-1:0] d, input bit l,
                       input bit t, input bit c, output bit acc);
        bit fs, us;
        exp_t e;
        @(posedge SYS_CLK);
        #2;
        RST = r; S_TVALID = v; S_TDATA = d; S_TLAST = l; TRIG = t; ERR_CLR = c;
        acc = v && !r && !m_full;
        if (r) begin
            m_part.delete();
            m_full = 0; m_disc = 0; m_en = 0; m_ferr = 0; m_und = 0; m_front = '0;
        end else begin
            fs = 0;
            us = 0;
            if (t) begin
                if (m_full) begin
                    m_front = m_back;
                    m_en    = 1;
                    m_full  = 0;
                end else us = 1;
            end
            if (acc) begin
                if (m_disc) begin
                    if (l) m_disc = 0;
                end else begin
                    m_part.push_back(d);
                    if (m_part.size() == NW) begin
                        if (l) begin
                            for (int i = 0; i < NW; i++) m_back[i*WORD +: WORD] = m_part[i];
                            m_full = 1;
                        end else begin
                            fs     = 1;
                            m_disc = 1;
                        end
                        m_part.delete();
                    end else if (l) begin
                        fs = 1;
                        m_part.delete();
                    end
                end
            end
            m_ferr = fs | (m_ferr & !c);
            m_und  = us | (m_und & !c);
        end
        e.flags = {!r && !m_full, m_full, m_en, m_ferr, m_und};
        e.data  = m_front;
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input bit t, input bit c);
        bit acc;
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, t, c, acc);
    endtask

    task automatic do_reset(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cyc(1, $urandom_range(0, 1), WORD'($urandom), 0, $urandom_range(0, 1), 0, acc);
    endtask

    // A beat blocked for four attempts gets a TRIG to free the back buffer.
    task automatic frame(input int n, input int last_at, input bit incr, input int trig_at);
        bit acc;
        int tries;
        logic [WORD-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = incr ? WORD'(k) : WORD'($urandom);
            tries = 0;
            do begin
                cyc(0, 1, d, k == last_at, (k == trig_at && tries == 0) || tries == 4, 0, acc);
                tries++;
            end while (!acc && tries < 60);
            if (!acc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat_accept: beat %0d not accepted after %0d tries", k, tries);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   w;
        forever begin
            @(posedge SYS_CLK);
            #1;
            n_cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if ({S_TREADY, LOADED, EN, FRAME_ERR, UNDERRUN} !== e.flags || DATA !== e.data) begin
                    n_bad++;
                    w = 0;
                    for (int i = NW - 1; i >= 0; i--) if (DATA[i*WORD +: WORD] !== e.data[i*WORD +: WORD]) w = i;
                    $display("FAIL cycle %0d: rdy/ld/en/ferr/und got %b want %b; DATA word %0d got %h want %h",
                             n_cyc, {S_TREADY, LOADED, EN, FRAME_ERR, UNDERRUN}, e.flags,
                             w, DATA[w*WORD +: WORD], e.data[w*WORD +: WORD]);
                end
            end
        end
    end

    initial begin : stim
        bit acc;
        bit r, v, l, t, c;
        do_reset(3);
        idle(2, 0, 0);
        idle(1, 1, 0);
        idle(2, 0, 0);
        idle(1, 0, 1);
        frame(NW, NW - 1, 1, -1);
        idle(2, 0, 0);
        idle(1, 1, 0);
        idle(3, 0, 0);
        frame(NW, NW - 1, 0, -1);
        frame(NW, NW - 1, 0, -1);
        idle(2, 0, 0);
        idle(1, 1, 0);
        idle(2, 0, 0);
        frame(50, 49, 0, -1);
        frame(NW + 3, NW + 2, 0, -1);
        frame(NW, NW - 1, 0, -1);
        idle(1, 1, 1);
        idle(2, 0, 0);
        idle(1, 0, 1);
        frame(NW, NW - 1, 0, NW - 1);
        idle(3, 0, 0);
        idle(1, 1, 0);
        idle(2, 0, 0);
        frame(61, -1, 1, -1);
        do_reset(2);
        idle(1, 0, 0);
        frame(NW, NW - 1, 0, -1);
        idle(1, 1, 0);
        idle(2, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 599) == 0;
            v = $urandom_range(0, 3) != 0;
            l = (!m_disc && m_part.size() == NW - 1) ? $urandom_range(0, 7) != 0 : $urandom_range(0, 79) == 0;
            t = $urandom_range(0, 59) == 0;
            c = $urandom_range(0, 49) == 0;
            cyc(r, v, WORD'($urandom), l, t, c, acc);
        end
        idle(3, 0, 0);
        @(posedge SYS_CLK);
        #3;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
